// File: rtl/escape_sequence_encoder_if.sv
// Request/transmit bus of the escape sequence encoder.
// master: request source and UART transmitter side. slave: the encoder.
interface escape_sequence_encoder_if;
  logic       reqValid;
  logic       reqReady;
  logic [2:0] reqType;
  logic [7:0] reqPn1;
  logic [7:0] reqPn2;
  logic       cursorApp;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;

  modport master (
    output reqValid, reqType, reqPn1, reqPn2, cursorApp, txReady,
    input  reqReady, txData, txValid
  );

  modport slave (
    input  reqValid, reqType, reqPn1, reqPn2, cursorApp, txReady,
    output reqReady, txData, txValid
  );
endinterface

// File: rtl/escape_sequence_encoder.sv
// Escape sequence encoder: serializes one abstract terminal request into
// its VT100/ANSI byte sequence, one byte per valid/ready transfer.
// Optional build macro ESCENC_C1_CSI_EN: CSI-introduced sequences start with
// the 8-bit C1 byte 0x9B and application-mode keys with 0x8F instead of the
// two-byte 7-bit introducers.
//
// state  | meaning
// IDLE   | waiting for a request, reqReady=1
// ESC    | sending 0x1B
// CSI    | sending '[' (0x9B in C1 build)
// SS3    | sending 'O' (0x8F in C1 build)
// QUES   | sending '?'
// DA_DIG | sending the device attribute digit
// P1_H   | Pn1 hundreds digit
// P1_T   | Pn1 tens digit
// P1_O   | Pn1 ones digit ('0' for DSR_OK)
// SEMI   | sending ';'
// P2_H   | Pn2 hundreds digit
// P2_T   | Pn2 tens digit
// P2_O   | Pn2 ones digit
// FINAL  | sending the final byte of the sequence
// RAW    | sending the CHAR byte verbatim
module escape_sequence_encoder #(
  parameter int unsigned DA_CODE = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  escape_sequence_encoder_if.slave    bus,
  output logic [7:0]                  debug
);

`ifdef ESCENC_C1_CSI_EN
  localparam bit C1_EN = 1'b1;
`else
  localparam bit C1_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ESC    = 4'd1,
    CSI    = 4'd2,
    SS3    = 4'd3,
    QUES   = 4'd4,
    DA_DIG = 4'd5,
    P1_H   = 4'd6,
    P1_T   = 4'd7,
    P1_O   = 4'd8,
    SEMI   = 4'd9,
    P2_H   = 4'd10,
    P2_T   = 4'd11,
    P2_O   = 4'd12,
    FINAL  = 4'd13,
    RAW    = 4'd14
  } state_t;

  localparam logic [2:0] T_CHAR = 3'd0;
  localparam logic [2:0] T_UP   = 3'd1;
  localparam logic [2:0] T_DOWN = 3'd2;
  localparam logic [2:0] T_RGHT = 3'd3;
  localparam logic [2:0] T_LEFT = 3'd4;
  localparam logic [2:0] T_CPR  = 3'd5;
  localparam logic [2:0] T_DSR  = 3'd6;
  localparam logic [2:0] T_DA   = 3'd7;

  localparam logic [7:0] DA_BYTE = 8'h30 + 8'(DA_CODE);

  state_t     state_q, state_d;
  logic [2:0] type_q, type_d;
  logic [7:0] pn1_q, pn1_d;
  logic [7:0] pn2_q, pn2_d;
  logic       app_q, app_d;

  logic [7:0] cur_v, hund, tens, ones;
  logic       key_in, key_q;
  logic [7:0] tx_data;

  // Leading-zero suppression: start at the most significant non-zero digit.
  function automatic state_t first_digit(input logic [7:0] v, input state_t h,
                                         input state_t t, input state_t o);
    if (v >= 8'd100)     return h;
    else if (v >= 8'd10) return t;
    else                 return o;
  endfunction

  // Decimal digits of the captured parameter currently being rendered.
  always_comb begin
    cur_v = (state_q == P2_H || state_q == P2_T || state_q == P2_O) ? pn2_q : pn1_q;
    hund  = cur_v / 8'd100;
    tens  = (cur_v / 8'd10) % 8'd10;
    ones  = cur_v % 8'd10;
  end

  assign key_in = (bus.reqType >= T_UP) && (bus.reqType <= T_LEFT);
  assign key_q  = (type_q >= T_UP) && (type_q <= T_LEFT);

  // Next-state, capture and byte selection.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    pn1_d   = pn1_q;
    pn2_d   = pn2_q;
    app_d   = app_q;
    tx_data = 8'h00;
    case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          type_d = bus.reqType;
          pn1_d  = bus.reqPn1;
          pn2_d  = bus.reqPn2;
          app_d  = bus.cursorApp;
          if (bus.reqType == T_CHAR)        state_d = RAW;
          else if (key_in && bus.cursorApp) state_d = C1_EN ? SS3 : ESC;
          else                              state_d = C1_EN ? CSI : ESC;
        end
      end
      ESC: begin
        tx_data = 8'h1B;
        if (bus.txReady) state_d = (key_q && app_q) ? SS3 : CSI;
      end
      CSI: begin
        tx_data = C1_EN ? 8'h9B : 8'h5B;
        if (bus.txReady) begin
          case (type_q)
            T_CPR:   state_d = first_digit(pn1_q, P1_H, P1_T, P1_O);
            T_DSR:   state_d = P1_O;
            T_DA:    state_d = QUES;
            default: state_d = FINAL;
          endcase
        end
      end
      SS3: begin
        tx_data = C1_EN ? 8'h8F : 8'h4F;
        if (bus.txReady) state_d = FINAL;
      end
      QUES: begin
        tx_data = 8'h3F;
        if (bus.txReady) state_d = DA_DIG;
      end
      DA_DIG: begin
        tx_data = DA_BYTE;
        if (bus.txReady) state_d = FINAL;
      end
      P1_H, P2_H: begin
        tx_data = 8'h30 + hund;
        if (bus.txReady) state_d = (state_q == P1_H) ? P1_T : P2_T;
      end
      P1_T, P2_T: begin
        tx_data = 8'h30 + tens;
        if (bus.txReady) state_d = (state_q == P1_T) ? P1_O : P2_O;
      end
      P1_O: begin
        tx_data = (type_q == T_CPR) ? (8'h30 + ones) : 8'h30;
        if (bus.txReady) state_d = (type_q == T_CPR) ? SEMI : FINAL;
      end
      SEMI: begin
        tx_data = 8'h3B;
        if (bus.txReady) state_d = first_digit(pn2_q, P2_H, P2_T, P2_O);
      end
      P2_O: begin
        tx_data = 8'h30 + ones;
        if (bus.txReady) state_d = FINAL;
      end
      FINAL: begin
        case (type_q)
          T_UP:    tx_data = 8'h41;
          T_DOWN:  tx_data = 8'h42;
          T_RGHT:  tx_data = 8'h43;
          T_LEFT:  tx_data = 8'h44;
          T_CPR:   tx_data = 8'h52;
          T_DSR:   tx_data = 8'h6E;
          default: tx_data = 8'h63;
        endcase
        if (bus.txReady) state_d = IDLE;
      end
      RAW: begin
        tx_data = pn1_q;
        if (bus.txReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      type_q  <= 3'd0;
      pn1_q   <= 8'd0;
      pn2_q   <= 8'd0;
      app_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pn1_q   <= pn1_d;
      pn2_q   <= pn2_d;
      app_q   <= app_d;
    end
  end

  assign bus.reqReady = (state_q == IDLE);
  assign bus.txValid  = (state_q != IDLE);
  assign bus.txData   = tx_data;
  assign debug        = {4'b0000, state_q};

endmodule

// File: tb/tb_escape_sequence_encoder.sv
// Self-checking bench for escape_sequence_encoder: vector table plus a byte
// scoreboard checked on every transfer, and hand sequences for stall and reset.
module tb_escape_sequence_encoder;
  localparam int unsigned DA_CODE = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] debug;

  escape_sequence_encoder_if bus ();

  escape_sequence_encoder #(.DA_CODE(DA_CODE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .debug (debug)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic        app;
    int          len;
    logic [63:0] b;   // first byte leftmost
  } vec_t;

  vec_t       tbl[12];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: compare each transferred byte; check hold during stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_valid", 32'(bus.txValid), 32'd1);
        chk("stall_data", 32'(bus.txData), 32'(held));
      end
      if (bus.txValid && bus.txReady) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(bus.txData), 32'h1FF);
        else chk("tx_byte", 32'(bus.txData), 32'(exp_q.pop_front()));
      end
      stall_prev = bus.txValid && !bus.txReady;
      held = bus.txData;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_expected(input vec_t v, output int n);
    int start;
    logic [7:0] b0, b1;
    start = 0;
    n = 0;
    b0 = v.b[(v.len-1)*8 +: 8];
    b1 = (v.len > 1) ? v.b[(v.len-2)*8 +: 8] : 8'h00;
`ifdef ESCENC_C1_CSI_EN
    if (v.t != 3'd0 && b0 == 8'h1B && (b1 == 8'h5B || b1 == 8'h4F)) begin
      exp_q.push_back(b1 == 8'h5B ? 8'h9B : 8'h8F);
      n = 1;
      start = 2;
    end
`endif
    for (int i = start; i < v.len; i++) begin
      exp_q.push_back(v.b[(v.len-1-i)*8 +: 8]);
      n++;
    end
  endtask

  // Caller is at posedge+1. Issues one request and waits for return to IDLE.
  task automatic run_req(input vec_t v, input bit alt, input bit pulse);
    int n, cyc;
    push_expected(v, n);
    bus.reqType = v.t; bus.reqPn1 = v.p1; bus.reqPn2 = v.p2;
    bus.cursorApp = v.app; bus.reqValid = 1'b1; bus.txReady = 1'b1;
    chk("ready_before_accept", 32'(bus.reqReady), 32'd1);
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    bus.reqType = ~v.t; bus.reqPn1 = ~v.p1; bus.reqPn2 = v.p2 ^ 8'h5A;
    chk("first_byte_latency", 32'(bus.txValid), 32'd1);
    cyc = 0;
    while (!bus.reqReady && cyc < 200) begin
      bus.cursorApp = ~bus.cursorApp;
      if (alt) bus.txReady = ~bus.txReady;
      if (pulse && cyc == 3) begin
        bus.reqValid = 1'b1;
        chk("busy_not_ready", 32'(bus.reqReady), 32'd0);
      end else begin
        bus.reqValid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.reqValid = 1'b0;
    bus.txReady = 1'b1;
    if (cyc >= 200) chk("timeout", 32'(cyc), 32'd0);
    if (!alt) chk("seq_cycles", 32'(cyc), 32'(n));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t v;
    int n;
    tbl[0]  = '{3'd5, 8'd12,  8'd5,   1'b0, 7, 64'h1B5B31323B3552};
    tbl[1]  = '{3'd5, 8'd0,   8'd255, 1'b0, 8, 64'h1B5B303B32353552};
    tbl[2]  = '{3'd5, 8'd100, 8'd9,   1'b0, 8, 64'h1B5B3130303B3952};
    tbl[3]  = '{3'd1, 8'd0,   8'd0,   1'b0, 3, 64'h1B5B41};
    tbl[4]  = '{3'd4, 8'd0,   8'd0,   1'b1, 3, 64'h1B4F44};
    tbl[5]  = '{3'd0, 8'h1B,  8'd0,   1'b0, 1, 64'h1B};
    tbl[6]  = '{3'd6, 8'd77,  8'd3,   1'b0, 4, 64'h1B5B306E};
    tbl[7]  = '{3'd2, 8'd0,   8'd0,   1'b1, 3, 64'h1B4F42};
    tbl[8]  = '{3'd3, 8'd0,   8'd0,   1'b0, 3, 64'h1B5B43};
    tbl[9]  = '{3'd5, 8'd99,  8'd10,  1'b0, 8, 64'h1B5B39393B313052};
    tbl[10] = '{3'd0, 8'h41,  8'd0,   1'b1, 1, 64'h41};
    tbl[11] = '{3'd7, 8'd0,   8'd0,   1'b0, 5, 64'h1B5B3F3663};

    bus.reqValid = 1'b0; bus.reqType = 3'd0; bus.reqPn1 = 8'd0;
    bus.reqPn2 = 8'd0; bus.cursorApp = 1'b0; bus.txReady = 1'b1;
    #2;
    chk("reset_txValid", 32'(bus.txValid), 32'd0);
    chk("reset_txData", 32'(bus.txData), 32'd0);
    chk("reset_reqReady", 32'(bus.reqReady), 32'd1);
    chk("reset_debug", 32'(debug), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_req(tbl[i], 1'b0, 1'b0);

    // DA with txReady toggling every cycle and a stray request mid-sequence.
    run_req(tbl[11], 1'b1, 1'b1);

    // Reset after the third byte of CPR 123;45.
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h5B);
    exp_q.push_back(8'h31);
`ifdef ESCENC_C1_CSI_EN
    void'(exp_q.pop_front());
    exp_q[0] = 8'h9B;
    exp_q.push_back(8'h32);
`endif
    bus.reqType = 3'd5; bus.reqPn1 = 8'd123; bus.reqPn2 = 8'd45;
    bus.reqValid = 1'b1; bus.txReady = 1'b1;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txValid", 32'(bus.txValid), 32'd0);
    chk("rst_mid_reqReady", 32'(bus.reqReady), 32'd1);
    chk("rst_mid_debug", 32'(debug), 32'd0);
    chk("rst_mid_bytes_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_req(tbl[11], 1'b0, 1'b0);

    v = tbl[6];
    push_expected(v, n);
    exp_q.delete();
    chk("model_dsr_len", 32'(n), 32'(v.len
`ifdef ESCENC_C1_CSI_EN
      - 1
`endif
    ));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
